// File: rtl/neuron_fork_if.sv
// neuron_fork_if: accumulator input stream and broadcast state output bundle for neuron_fork
// Ports (signals):
//   iMode, iValid_AM_Accum0, iData_AM_Accum0 / oReady_AM_Accum0 : accumulator beat handshake
//   oValid_BM_State[NB], iReady_BM_State[NB], oData_BM_State     : per-consumer broadcast handshake
// Modports: slave = neuron_fork view, master = producer/consumer (testbench) view.
interface neuron_fork_if #(
  parameter int NC = 8,
  parameter int WA = 6,
  parameter int WN = 4,
  parameter int NB = 2
);
  logic iMode;
  logic iValid_AM_Accum0;
  logic oReady_AM_Accum0;
  logic [NC*WA-1:0] iData_AM_Accum0;
  logic [NB-1:0] oValid_BM_State;
  logic [NB-1:0] iReady_BM_State;
  logic [NC*WN-1:0] oData_BM_State;
  modport slave (
    input iMode, iValid_AM_Accum0, iData_AM_Accum0, iReady_BM_State,
    output oReady_AM_Accum0, oValid_BM_State, oData_BM_State
  );
  modport master (
    output iMode, iValid_AM_Accum0, iData_AM_Accum0, iReady_BM_State,
    input oReady_AM_Accum0, oValid_BM_State, oData_BM_State
  );
endinterface

// File: rtl/neuron_fork.sv
// neuron_fork: activates a beat of NC accumulators, buffers it in a 2-entry FIFO and broadcasts it to NB consumers
// Ports:
//   iCLK, iRST  : clock, asynchronous active-high reset
//   bus (slave) : accumulator input handshake + per-consumer broadcast handshake (see neuron_fork_if)
//   oSatCount   : count of positive-clamp events
// Optional feature: define NEURON_FORK_SATSTAT_EN to build the saturation event counter;
// otherwise oSatCount is tied to zero.
module neuron_fork #(
  parameter string HIDDEN = "yes",
  parameter int NP = 4,
  parameter int NC = 8,
  parameter int WV = 4,
  parameter int NB = 2
) (
  input  logic iCLK,
  input  logic iRST,
  neuron_fork_if.slave bus,
  output logic [15:0] oSatCount
);
  localparam int WA = $clog2(NP) + WV;
  localparam int WN = (HIDDEN == "yes") ? WV : WA;
  localparam logic signed [WA-1:0] MAXV = WA'(2 ** (WV - 1) - 1);
  logic [NC*WN-1:0] w_act;
  logic [NC-1:0] w_pos;
  logic [NC*WN-1:0] r_data [2];
  logic [1:0] r_mode;
  logic r_wr, r_rd;
  logic [1:0] r_cnt;
  logic [NB-1:0] r_done;
  logic w_acc, w_hv, w_retire;
  logic [NB-1:0] w_en, w_xfer;
  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic signed [WA-1:0] w_a;
    assign w_a = bus.iData_AM_Accum0[c*WA +: WA];
    if (HIDDEN == "yes") begin : g_relu
      assign w_pos[c] = w_a > MAXV;
      assign w_act[c*WN +: WN] = w_a[WA-1] ? '0 : w_pos[c] ? WN'(MAXV) : w_a[WN-1:0];
    end else begin : g_lin
      assign w_pos[c] = 1'b0;
      assign w_act[c*WN +: WN] = w_a;
    end
  end
  assign bus.oReady_AM_Accum0 = (r_cnt < 2'd2) & ~iRST;
  assign w_acc = bus.iValid_AM_Accum0 & bus.oReady_AM_Accum0;
  assign w_hv = r_cnt != 2'd0;
  // consumer 0 takes every entry; the rest only see training-mode entries
  assign w_en = r_mode[r_rd] ? '1 : NB'(1);
  assign bus.oValid_BM_State = {NB{w_hv}} & w_en & ~r_done;
  assign w_xfer = bus.oValid_BM_State & bus.iReady_BM_State;
  assign w_retire = w_hv && ((w_en & ~(r_done | w_xfer)) == '0);
  assign bus.oData_BM_State = r_data[r_rd];
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      r_data <= '{default: '0};
      r_mode <= '0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_cnt <= '0;
      r_done <= '0;
    end else begin
      if (w_acc) begin
        r_data[r_wr] <= w_act;
        r_mode[r_wr] <= bus.iMode;
        r_wr <= ~r_wr;
      end
      if (w_retire) r_rd <= ~r_rd;
      r_done <= w_retire ? '0 : r_done | w_xfer;
      r_cnt <= r_cnt + 2'(w_acc) - 2'(w_retire);
    end
`ifdef NEURON_FORK_SATSTAT_EN
  logic [15:0] r_sat;
  logic [16:0] w_sum;
  assign w_sum = {1'b0, r_sat} + 17'($countones(w_pos));
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) r_sat <= '0;
    else if (w_acc) r_sat <= w_sum[16] ? 16'hffff : w_sum[15:0];
  assign oSatCount = r_sat;
`else
  assign oSatCount = '0;
`endif
endmodule

// File: tb/tb_neuron_fork.sv
// tb_neuron_fork: scoreboard bench for neuron_fork (clamped and pass-through builds side by side)
module tb_neuron_fork;
  logic clk = 0, rst = 1, mode = 0, vld = 0;
  logic [1:0] rdy = 2'b11;
  logic [47:0] din = '0;
  logic [15:0] sat_y, sat_n;
  int n_chk = 0, n_pass = 0, cyc = 0, exp_sat = 0, last_acc = 0, a1 = 0;
  logic [47:0] qy0[$], qy1[$], qn0[$], qn1[$];
  int vin [4][8] = '{'{-7, -4, -1, 2, 5, 8, 11, 14}, '{0, 1, 7, 8, -8, -1, 3, 6},
                     '{31, -32, 4, -5, 7, 15, -16, 2}, '{6, 6, 6, 6, 6, 6, 6, 6}};
  int vy [4][8] = '{'{0, 0, 0, 2, 5, 7, 7, 7}, '{0, 1, 7, 7, 0, 0, 3, 6},
                    '{7, 0, 4, 0, 7, 7, 0, 2}, '{6, 6, 6, 6, 6, 6, 6, 6}};
  int vsat [4] = '{3, 1, 2, 0};
  neuron_fork_if #(.NC(8), .WA(6), .WN(4), .NB(2)) bus_y ();
  neuron_fork_if #(.NC(8), .WA(6), .WN(6), .NB(2)) bus_n ();
  assign bus_y.iMode = mode;
  assign bus_y.iValid_AM_Accum0 = vld;
  assign bus_y.iData_AM_Accum0 = din;
  assign bus_y.iReady_BM_State = rdy;
  assign bus_n.iMode = mode;
  assign bus_n.iValid_AM_Accum0 = vld;
  assign bus_n.iData_AM_Accum0 = din;
  assign bus_n.iReady_BM_State = rdy;
  neuron_fork #(.HIDDEN("yes")) u_y (.iCLK(clk), .iRST(rst), .bus(bus_y), .oSatCount(sat_y));
  neuron_fork #(.HIDDEN("no")) u_n (.iCLK(clk), .iRST(rst), .bus(bus_n), .oSatCount(sat_n));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string nm, logic [47:0] act, logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // monitor: every transfer is checked against the head of that consumer's queue
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst) begin
      if (bus_y.oValid_BM_State[0] && rdy[0]) begin
        e = qy0.size() != 0 ? qy0.pop_front() : 'x;
        check("hidden c0 data", {16'b0, bus_y.oData_BM_State}, e);
      end
      if (bus_y.oValid_BM_State[1] && rdy[1]) begin
        e = qy1.size() != 0 ? qy1.pop_front() : 'x;
        check("hidden c1 data", {16'b0, bus_y.oData_BM_State}, e);
      end
      if (bus_n.oValid_BM_State[0] && rdy[0]) begin
        e = qn0.size() != 0 ? qn0.pop_front() : 'x;
        check("linear c0 data", bus_n.oData_BM_State, e);
      end
      if (bus_n.oValid_BM_State[1] && rdy[1]) begin
        e = qn1.size() != 0 ? qn1.pop_front() : 'x;
        check("linear c1 data", bus_n.oData_BM_State, e);
      end
    end
  end
  task automatic send(int i, bit m);
    logic [47:0] ey = '0;
    int b = 0;
    @(posedge clk);
    #1;
    vld = 1;
    mode = m;
    for (int c = 0; c < 8; c++) begin
      din[c*6 +: 6] = 6'(vin[i][c]);
      ey[c*4 +: 4] = 4'(vy[i][c]);
    end
    forever begin
      @(negedge clk);
      if (bus_y.oReady_AM_Accum0) break;
      if (++b == 50) begin
        n_chk++;
        $display("FAIL send timeout: vector %0d not accepted within 50 cycles", i);
        return;
      end
    end
    qy0.push_back(ey);
    qn0.push_back(din);
    if (m) begin
      qy1.push_back(ey);
      qn1.push_back(din);
    end
    exp_sat += vsat[i];
    last_acc = cyc;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    vld = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset ready", {47'b0, bus_y.oReady_AM_Accum0}, 48'd0);
    check("reset valid", {46'b0, bus_y.oValid_BM_State}, 48'd0);
    check("reset data", {16'b0, bus_y.oData_BM_State}, 48'd0);
    check("reset sat", {32'b0, sat_y}, 48'd0);
    @(posedge clk);
    #1 rst = 0;
    send(0, 1);
    idle();
    @(negedge clk);
    check("latency valid", {46'b0, bus_y.oValid_BM_State}, 48'd3);
    check("latency valid linear", {46'b0, bus_n.oValid_BM_State}, 48'd3);
    repeat (2) @(negedge clk);
    send(1, 1);
    a1 = last_acc;
    send(2, 1);
    send(3, 1);
    check("throughput cycles", 48'(last_acc - a1), 48'd2);
    idle();
    repeat (3) @(negedge clk);
    rdy = 2'b01;
    send(0, 0);
    idle();
    repeat (4) begin
      @(negedge clk);
      check("inference c1 valid", {47'b0, bus_y.oValid_BM_State[1]}, 48'd0);
    end
    check("inference retired valid", {46'b0, bus_y.oValid_BM_State}, 48'd0);
    check("inference retired ready", {47'b0, bus_y.oReady_AM_Accum0}, 48'd1);
    fork
      begin
        send(1, 1);
        send(2, 1);
        send(3, 1);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 check("full ready", {47'b0, bus_y.oReady_AM_Accum0}, 48'd0);
        @(posedge clk);
        #1 check("blocked valid", {46'b0, bus_y.oValid_BM_State}, 48'd2);
        repeat (2) @(posedge clk);
        #1 rdy = 2'b11;
      end
    join
    repeat (4) @(negedge clk);
    rdy = 2'b00;
    send(0, 1);
    send(1, 1);
    idle();
    @(posedge clk);
    #3 check("pending valid", {46'b0, bus_y.oValid_BM_State}, 48'd3);
    rst = 1;
    #1;
    check("mid reset valid", {46'b0, bus_y.oValid_BM_State}, 48'd0);
    check("mid reset ready", {47'b0, bus_y.oReady_AM_Accum0}, 48'd0);
    check("mid reset data", {16'b0, bus_y.oData_BM_State}, 48'd0);
    check("mid reset sat", {32'b0, sat_y}, 48'd0);
    qy0.delete();
    qy1.delete();
    qn0.delete();
    qn1.delete();
    exp_sat = 0;
    @(negedge clk);
    rst = 0;
    #1 check("post reset ready", {47'b0, bus_y.oReady_AM_Accum0}, 48'd1);
    check("post reset valid", {46'b0, bus_y.oValid_BM_State}, 48'd0);
    rdy = 2'b11;
    send(0, 1);
    idle();
    for (int b = 0; b < 20 && (qy0.size() + qy1.size() + qn0.size() + qn1.size()) != 0; b++)
      @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 48'(qy0.size() + qy1.size() + qn0.size() + qn1.size()), 48'd0);
`ifdef NEURON_FORK_SATSTAT_EN
    check("sat count hidden", {32'b0, sat_y}, 48'(exp_sat));
`else
    check("sat count hidden", {32'b0, sat_y}, 48'd0);
`endif
    check("sat count linear", {32'b0, sat_n}, 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/neuron_fork.md
NEURON_FORK -- requirements
Module: neuron_fork

Interface
REQ-001 Parameter HIDDEN, default "yes": "yes" applies clamped ReLU, "no" passes the accumulator value through unchanged.
REQ-002 Parameter NP, default 4: parent count; accumulator width WA = $clog2(NP)+WV.
REQ-003 Parameters NC, default 8, and WV, default 4: NC is the child/channel count, WV is the value width; WN = WV if HIDDEN=="yes", else WA.
REQ-004 Parameter NB, default 2, legal range 2..8: number of broadcast consumers.
REQ-005 iCLK  in  1  clock; all state updates on the rising edge.
REQ-006 iRST  in  1  reset; asynchronous, active-high.
REQ-007 iMode  in  1  0 = inference, 1 = training; sampled per accepted beat.
REQ-008 iValid_AM_Accum0  in  1  input beat valid.
REQ-009 oReady_AM_Accum0  out  1  input beat can be accepted.
REQ-010 iData_AM_Accum0  in  NC*WA  signed accumulators; channel c at bits [c*WA +: WA].
REQ-011 oValid_BM_State  out  NB  per-consumer output valid.
REQ-012 iReady_BM_State  in  NB  per-consumer ready.
REQ-013 oData_BM_State  out  NC*WN  activated state shared by all consumers; channel c at bits [c*WN +: WN].
REQ-014 oSatCount  out  16  positive-saturation event count (see Configuration).

Function
REQ-015 A beat SHALL be accepted in a cycle with iValid_AM_Accum0=1 and oReady_AM_Accum0=1; the activated data and the sampled iMode SHALL be stored together as one entry in a 2-entry FIFO.
REQ-016 oReady_AM_Accum0 SHALL equal (occupancy<2) AND NOT iRST; it SHALL NOT depend on iReady_BM_State.
REQ-017 HIDDEN=="yes": per channel, a<0 gives 0; a>2^(WV-1)-1 gives 2^(WV-1)-1; otherwise a[WV-1:0]. HIDDEN=="no": identity.
REQ-018 The head entry SHALL drive oData_BM_State; data SHALL hold stable until the head entry retires.
REQ-019 Consumer 0 SHALL be enabled for every entry; consumers 1..NB-1 SHALL be enabled only for entries whose stored mode=1.
REQ-020 oValid_BM_State[k] SHALL equal headValid AND enabled(k) AND NOT done[k].
REQ-021 A transfer to consumer k occurs when oValid_BM_State[k]=1 and iReady_BM_State[k]=1; done[k] SHALL then set.
REQ-022 The head entry SHALL retire in the cycle in which every enabled consumer is done or transferring; on retire all done bits SHALL clear.
REQ-023 Latency: a beat accepted in cycle t SHALL appear on oValid_BM_State in cycle t+1 when the FIFO was empty.
REQ-024 Sustained throughput SHALL be 1 beat/cycle when all enabled consumers hold ready high.
REQ-025 Accept and retire in the same cycle SHALL leave occupancy unchanged and SHALL lose no data.
REQ-026 A change on iMode SHALL NOT affect entries already stored.
REQ-027 Consumers may accept in any order or cycle; no consumer SHALL receive the same entry twice.

Reset
REQ-028 While iRST=1: occupancy=0, all done bits=0, oValid_BM_State=0, oReady_AM_Accum0=0, oData_BM_State=0, oSatCount=0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored entries immediately; oReady_AM_Accum0 SHALL rise in the first cycle after iRST falls.

Configuration
REQ-030 Macro NEURON_FORK_SATSTAT_EN defined: on each accepted beat with HIDDEN=="yes", oSatCount SHALL add the number of channels clamped at the positive limit, saturating at 65535.
REQ-031 Macro NEURON_FORK_SATSTAT_EN undefined: oSatCount SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 Use NP=4, NC=8, WV=4, NB=2, HIDDEN="yes", iMode=1; input channels -7+3c (-7,-4,-1,2,5,8,11,14), both readies high -> output 0,0,0,2,5,7,7,7 one cycle after accept, both oValid high.
REQ-033 Same as REQ-032 with HIDDEN="no" -> output -7..14 unchanged (WN=6).
REQ-034 iMode=0, iReady_BM_State=2'b01 -> oValid_BM_State=2'b01, entry retires; oValid_BM_State[1] never high.
REQ-035 iMode=1, iReady_BM_State[1]=0 for 5 cycles, then 1; iValid held high -> two entries accepted, oReady falls, consumer 0 receives each entry exactly once, no loss after release.
REQ-036 iRST pulsed while 2 entries are pending -> oValid_BM_State=0 immediately; oReady_AM_Accum0=1 in the first cycle after release.
REQ-037 With NEURON_FORK_SATSTAT_EN defined, 10 beats of the REQ-032 stimulus -> oSatCount=30; with the macro undefined, oSatCount=0.
